// File: rtl/mcmem_pkg.sv
// mcmem shared types: FSM encoding, word-index slice position, default widths.
package mcmem_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam int WORD_LSB = 2;
    localparam int DW = 32;

    localparam int DEF_AW = 10;
    localparam int DEF_WAIT_CYCLES = 2;
    localparam int DEF_CW = 4;

endpackage

// File: rtl/mcmem_ram.sv
// mcmem single-port word RAM with registered read data.
module mcmem_ram
    import mcmem_pkg::*;
#(
    parameter int AW = DEF_AW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          en,
    input  logic          we,
    input  logic          clr,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // A reset landing on the access edge must not commit the write.
    always_ff @(posedge clock) begin
        if (en && we && !reset) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            rdata <= '0;
        end else if (en) begin
            rdata <= we ? wdata : mem[addr];
        end
    end

endmodule

// File: rtl/mcmem_ctrl.sv
// mcmem controller: request capture, wait-state FSM, RAM access sequencing.
// Optional MCMEM_ALIGN_CHECK_EN flags and suppresses misaligned accesses.
module mcmem_ctrl
    import mcmem_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int CW = DEF_CW
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        wmem,
    input  logic [31:0] madr,
    input  logic [31:0] tomem,
    output logic [31:0] frommem,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    localparam logic [CW-1:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wmem_q;
    logic [AW+1:0] madr_q;
    logic [31:0]   tomem_q;
    logic          capture;
    logic          ram_en;
    logic          misaligned;
    logic          unused_bits;

`ifdef MCMEM_ALIGN_CHECK_EN
    assign misaligned = |madr_q[WORD_LSB-1:0];
    assign unused_bits = ^{madr[31:AW+2]};
`else
    assign misaligned = 1'b0;
    assign unused_bits = ^{madr[31:AW+2], madr_q[WORD_LSB-1:0]};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        ram_en  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    capture = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_ACCESS;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_ACCESS: begin
                ram_en  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wmem_q  <= 1'b0;
            madr_q  <= '0;
            tomem_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                wmem_q  <= wmem;
                madr_q  <= madr[AW+1:0];
                tomem_q <= tomem;
            end
        end
    end

    mcmem_ram #(
        .AW(AW)
    ) u_ram (
        .clock(clock),
        .reset(reset),
        .en   (ram_en),
        .we   (wmem_q & ~misaligned),
        .clr  (ram_en & misaligned),
        .addr (madr_q[AW+1:WORD_LSB]),
        .wdata(tomem_q),
        .rdata(frommem)
    );

    assign ready = (state_q == S_DONE);
    assign busy  = (state_q != S_IDLE);
    assign err   = ready & misaligned;

endmodule

// File: tb/tb_mcmem_ctrl.sv
// Scoreboard bench for mcmem_ctrl (WAIT_CYCLES=2 main instance, WAIT_CYCLES=0 side instance).
module tb_mcmem_ctrl;

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        req, wmem;
    logic [31:0] madr, tomem, frommem;
    logic        ready, busy, err;
    logic        req0, wmem0;
    logic [31:0] madr0, tomem0, frommem0;
    logic        ready0, busy0, err0;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [31:0] model [int];

    mcmem_ctrl #(.AW(10), .WAIT_CYCLES(2), .CW(4)) dut (
        .clock(clock), .reset(reset), .req(req), .wmem(wmem),
        .madr(madr), .tomem(tomem), .frommem(frommem),
        .ready(ready), .busy(busy), .err(err)
    );

    mcmem_ctrl #(.AW(10), .WAIT_CYCLES(0), .CW(4)) dut0 (
        .clock(clock), .reset(reset), .req(req0), .wmem(wmem0),
        .madr(madr0), .tomem(tomem0), .frommem(frommem0),
        .ready(ready0), .busy(busy0), .err(err0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && ready) begin
            if (sb.size() == 0) begin
                check("spurious_ready", {31'b0, ready}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("frommem", frommem, mon_e.d);
                check("err", {31'b0, err}, {31'b0, mon_e.e});
            end
        end
    end

    task automatic xfer(input bit w, input logic [31:0] a,
                        input logic [31:0] d);
        exp_t e;
        int   idx;
        int   n;
        bit   mis;
        idx = int'(a[11:2]);
        mis = 1'b0;
`ifdef MCMEM_ALIGN_CHECK_EN
        mis = (a[1:0] != 2'b00);
`endif
        if (mis) begin
            e.d = '0;
            e.e = 1'b1;
        end else if (w) begin
            model[idx] = d;
            e.d = d;
            e.e = 1'b0;
        end else begin
            e.d = model[idx];
            e.e = 1'b0;
        end
        sb.push_back(e);
        @(negedge clock);
        req = 1'b1; wmem = w; madr = a; tomem = d;
        @(posedge clock);
        #1;
        req = 1'b0;
        madr = $urandom();
        tomem = $urandom();
        wmem = 1'($urandom_range(0, 1));
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!ready && n < 30);
        check("latency", 32'(n), 32'd4);
        @(negedge clock);
        check("ready_pulse", {31'b0, ready}, 32'd0);
    endtask

    task automatic xfer0(input bit w, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] exp);
        int nr;
        int nb;
        nr = 0;
        nb = 0;
        @(negedge clock);
        req0 = 1'b1; wmem0 = w; madr0 = a; tomem0 = d;
        @(posedge clock);
        #1;
        req0 = 1'b0;
        madr0 = $urandom();
        tomem0 = $urandom();
        for (int i = 1; i <= 6; i++) begin
            @(negedge clock);
            if (busy0) nb++;
            if (ready0 && nr == 0) begin
                nr = i;
                check("w0_frommem", frommem0, exp);
            end
        end
        check("w0_latency", 32'(nr), 32'd2);
        check("w0_busy_cycles", 32'(nb), 32'd2);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        reset = 1'b1;
        req = 1'b1; wmem = 1'b1; madr = 32'h10; tomem = 32'hFFFF_FFFF;
        req0 = 1'b1; wmem0 = 1'b1; madr0 = 32'h10; tomem0 = 32'hFFFF_FFFF;
        repeat (3) begin
            @(negedge clock);
            check("rst_busy", {31'b0, busy}, 32'd0);
            check("rst_ready", {31'b0, ready}, 32'd0);
            check("rst_frommem", frommem, 32'd0);
            check("rst_err", {31'b0, err}, 32'd0);
            check("rst_busy0", {31'b0, busy0}, 32'd0);
            check("rst_frommem0", frommem0, 32'd0);
        end
        reset = 1'b0;
        req = 1'b0;
        req0 = 1'b0;

        xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        xfer(1'b0, 32'h0000_0010, 32'h0);

        xfer(1'b1, 32'h0000_0004, 32'h1234_5678);
        xfer(1'b0, 32'h0000_1004, 32'h0);

        xfer(1'b1, 32'h0000_0020, 32'h1111_2222);
        @(negedge clock);
        req = 1'b1; wmem = 1'b1; madr = 32'h20; tomem = 32'hA5A5_A5A5;
        @(posedge clock);
        #1;
        req = 1'b0;
        @(negedge clock);
        check("busy_in_wait", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (6) begin
            @(negedge clock);
            check("busy_after_rst", {31'b0, busy}, 32'd0);
        end
        xfer(1'b0, 32'h0000_0020, 32'h0);

        xfer(1'b1, 32'h0000_0022, 32'hCAFE_F00D);
        xfer(1'b0, 32'h0000_0020, 32'h0);

        xfer0(1'b1, 32'h0000_0040, 32'h0BAD_F00D, 32'h0BAD_F00D);
        xfer0(1'b0, 32'h0000_0040, 32'h0, 32'h0BAD_F00D);

        for (int i = 0; i < 6; i++) begin
            a = $urandom();
            a[1:0] = 2'b00;
            d = $urandom();
            xfer(1'b1, a, d);
            a[31:12] = 20'($urandom());
            xfer(1'b0, a, 32'h0);
        end

        repeat (3) @(negedge clock);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
